fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage and IF/ID pipeline register of the MIPS core. Holds the PC, reads instruction memory, and registers the fetched instruction and PC+4 for decode, where the opcode feeds the control decoder. Consumes the decoder's Branch/Jump outputs, plus the ALU-side zero flag, to redirect the PC. Squashes the wrong-path instruction on a taken redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hazard-unit stall; holds PC and IF/ID
- branch_i  in  1  Branch from control decoder (instruction in ID)
- jump_i  in  1  Jump from control decoder (instruction in ID)
- zero_i  in  1  equality result for the beq in ID
- imm_i  in  32  sign-extended immediate of the instruction in ID
- imem_addr_o  out  32  instruction memory address (= PC)
- imem_data_i  in  32  instruction word, combinational read of imem_addr_o
- ifid_instr_o  out  32  registered instruction to decode
- ifid_pc4_o  out  32  registered PC+4 of that instruction
- ifid_valid_o  out  1  1 = IF/ID holds a real fetched instruction
- flush_o  out  1  combinational; 1 in the cycle a redirect is taken
- pc_o  out  32  current PC (debug)

## Operation
- State: PC register; IF/ID register {instr, pc4, valid}.
- Targets:
  - branch target = ifid_pc4_o + (imm_i << 2), mod 2^32
  - jump target = {ifid_pc4_o[31:28], ifid_instr_o[25:0], 2'b00}
- Effective redirect: `jump_i & ifid_valid_o` (jump), `branch_i & zero_i & ifid_valid_o` (branch). Decode outputs are ignored when valid = 0.
- Next-state priority, highest first:
  1. rst_i: PC ← RESET_PC; IF/ID ← {32'h0, 32'h0, 0}
  2. stall_i: PC and IF/ID hold. Redirect is ignored and flush_o = 0; the ID instruction is re-evaluated after the stall.
  3. jump: PC ← jump target; IF/ID ← NOP (32'h0000_0000), pc4 0, valid 0; flush_o = 1
  4. taken branch: PC ← branch target; IF/ID squashed as in 3; flush_o = 1
  5. otherwise: PC ← PC + 4; IF/ID ← {imem_data_i, PC + 4, 1}
- Jump and taken branch together cannot occur from a legal decode; if forced, jump wins.
- PC + 4 wraps 32'hFFFF_FFFC → 32'h0000_0000 with no error.
- PC[1:0] is never written nonzero; the targets are word-aligned by construction.

## Timing
- Reset values: imem_addr_o = pc_o = RESET_PC; ifid_instr_o = 0; ifid_pc4_o = 0; ifid_valid_o = 0; flush_o = 0.
- Fetch latency: the word at PC appears on ifid_instr_o one edge after PC is presented.
- Redirect resolves in ID, giving a 1-cycle penalty. The sequential instruction fetched in the redirect cycle is discarded; the target is fetched in the next cycle and reaches ID one edge later.
- Stall: any number of consecutive cycles. The outputs stay bit-identical and no fetch is lost.
- Reset asserted mid-stall or mid-redirect: reset wins at that edge.
- Squashed NOP decodes as R-type sll $0 (harmless write to $0). valid = 0 additionally suppresses redirects.

## Structure
- Shared package `mips_pkg`:
  - NOP_INSTR = 32'h0000_0000
  - opcode constants: R-type 000000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010 (shared with the control decoder)
  - INSTR_W = 32
- Sub-module `pc_reg`: PC flop with reset value RESET_PC, hold enable, and load of next PC. The next-PC mux and the IF/ID register live in fetch_unit.

## Test plan
- Reset with RESET_PC = 0, imem[0..2] = A, B, C, 3 free-running cycles → ifid_instr = A, B, C; ifid_pc4 = 4, 8, 12; valid = 1.
- beq in ID with zero_i = 1, imm_i = 3, ifid_pc4 = 8 → next PC = 20, flush_o = 1, ifid becomes NOP with valid 0, then imem[20] reaches ID.
- Jump in ID with ifid_instr[25:0] = 26'h40, ifid_pc4 = 32'h1000_0008 → next PC = 32'h1000_0100, one squashed slot.
- stall_i held 3 cycles with a taken branch in ID → PC and IF/ID frozen, flush_o = 0; after release the branch redirects once.
- PC = 32'hFFFF_FFFC, no redirect → PC = 0, ifid_pc4 = 0, valid = 1.
- rst_i asserted during the redirect cycle → PC = RESET_PC, valid = 0, no target fetch.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared across the MIPS core (fetch, control decoder).
//   INSTR_W      instruction / datapath word width
//   NOP_INSTR    squash value for IF/ID; decodes as sll $0,$0,0
//   OP_*         6-bit primary opcodes recognised by the control decoder
//   jump_target  J-type target from the delay-slot-free PC+4 and instr_index
package mips_pkg;

   localparam int unsigned INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   function automatic logic [INSTR_W-1:0] jump_target(
      input logic [INSTR_W-1:0] pc4,
      input logic [INSTR_W-1:0] instr
   );
      return {pc4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter flop.
//   clk_i     clock
//   rst_i     synchronous active-high reset, loads RESET_PC
//   hold_i    1 = keep current PC
//   next_pc_i PC to load when not held
//   pc_o      current PC
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               hold_i,
   input  logic [INSTR_W-1:0] next_pc_i,
   output logic [INSTR_W-1:0] pc_o
);

   logic [INSTR_W-1:0] r_pc;

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_pc <= RESET_PC;
      else if (!hold_i)
         r_pc <= next_pc_i;
   end

   assign pc_o = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage plus IF/ID pipeline register.
//   clk_i, rst_i        clock, synchronous active-high reset
//   stall_i             freeze PC and IF/ID (redirects deferred)
//   branch_i, jump_i    decoder outputs for the instruction in ID
//   zero_i, imm_i       beq equality flag and sign-extended immediate
//   imem_addr_o/data_i  combinational instruction memory port
//   ifid_instr_o/pc4_o/valid_o  IF/ID register contents
//   flush_o             1 in the cycle a redirect is taken
//   pc_o                current PC
module fetch_unit
   import mips_pkg::*;
#(
   parameter logic [INSTR_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               stall_i,
   input  logic               branch_i,
   input  logic               jump_i,
   input  logic               zero_i,
   input  logic [INSTR_W-1:0] imm_i,
   output logic [INSTR_W-1:0] imem_addr_o,
   input  logic [INSTR_W-1:0] imem_data_i,
   output logic [INSTR_W-1:0] ifid_instr_o,
   output logic [INSTR_W-1:0] ifid_pc4_o,
   output logic               ifid_valid_o,
   output logic               flush_o,
   output logic [INSTR_W-1:0] pc_o
);

   logic [INSTR_W-1:0] r_instr;
   logic [INSTR_W-1:0] r_pc4;
   logic               r_valid;

   logic [INSTR_W-1:0] w_pc;
   logic [INSTR_W-1:0] w_pc4;
   logic [INSTR_W-1:0] w_br_tgt;
   logic [INSTR_W-1:0] w_j_tgt;
   logic [INSTR_W-1:0] w_next_pc;
   logic               w_jump;
   logic               w_br;
   logic               w_redirect;

   // Decode outputs only count when ID holds a real instruction.
   assign w_jump   = jump_i & r_valid;
   assign w_br     = branch_i & zero_i & r_valid;
   assign w_pc4    = w_pc + 32'd4;
   assign w_br_tgt = r_pc4 + {imm_i[INSTR_W-3:0], 2'b00};
   assign w_j_tgt  = jump_target(r_pc4, r_instr);

   // Stall defers the redirect; reset overrides everything at this edge.
   assign w_redirect = ~rst_i & ~stall_i & (w_jump | w_br);

   always_comb begin
      w_next_pc = w_pc4;
      if (w_jump)
         w_next_pc = w_j_tgt;
      else if (w_br)
         w_next_pc = w_br_tgt;
   end

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .hold_i    (stall_i),
      .next_pc_i (w_next_pc),
      .pc_o      (w_pc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_instr <= NOP_INSTR;
         r_pc4   <= '0;
         r_valid <= 1'b0;
      end else if (!stall_i) begin
         if (w_redirect) begin
            // Wrong-path sequential fetch is dropped.
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
         end else begin
            r_instr <= imem_data_i;
            r_pc4   <= w_pc4;
            r_valid <= 1'b1;
         end
      end
   end

   assign imem_addr_o  = w_pc;
   assign pc_o         = w_pc;
   assign ifid_instr_o = r_instr;
   assign ifid_pc4_o   = r_pc4;
   assign ifid_valid_o = r_valid;
   assign flush_o      = w_redirect;

endmodule
